// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, runs init/KSA/PRGA over an
// external S RAM and writes the length-prefixed ciphertext to the ct RAM.
module arc4_encrypt #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata
);

  typedef enum logic [3:0] {
    IDLE, INIT,
    KSA_RI, KSA_J, KSA_WI, KSA_WJ,
    PLEN_R, PLEN_W,
    PRGA_I, PRGA_J, PRGA_WI, PRGA_WJ, PRGA_PAD, PRGA_OUT,
    DONE
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             i, i_n, j, j_n, k, k_n, len, len_n;
  logic [7:0]             si, si_n, sj, sj_n;
  logic [7:0]             kidx, kidx_n;
  logic [8*KEY_BYTES-1:0] key_r, key_n;
  logic [7:0]             kb, jsum;

  // kidx tracks i mod KEY_BYTES incrementally instead of dividing
  always_comb begin
    kb = '0;
    for (int unsigned n = 0; n < KEY_BYTES; n++)
      if (kidx == 8'(n)) kb = key_r[8*(KEY_BYTES-n)-1 -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
      key_r <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      len   <= len_n;
      si    <= si_n;
      sj    <= sj_n;
      kidx  <= kidx_n;
      key_r <= key_n;
    end
  end

  always_comb begin
    state_n   = state;
    i_n       = i;
    j_n       = j;
    k_n       = k;
    len_n     = len;
    si_n      = si;
    sj_n      = sj;
    kidx_n    = kidx;
    key_n     = key_r;
    jsum      = '0;
    rdy       = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_n   = key;
          i_n     = '0;
          state_n = INIT;
        end
      end
      INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
        i_n      = i + 8'd1;
        if (i == 8'hFF) begin
          j_n     = '0;
          kidx_n  = '0;
          state_n = KSA_RI;
        end
      end
      KSA_RI: begin
        s_addr  = i;
        state_n = KSA_J;
      end
      KSA_J: begin
        si_n    = s_rddata;
        jsum    = j + s_rddata + kb;
        j_n     = jsum;
        s_addr  = jsum;
        state_n = KSA_WI;
      end
      KSA_WI: begin
        sj_n     = s_rddata;
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_n  = KSA_WJ;
      end
      KSA_WJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        i_n      = i + 8'd1;
        kidx_n   = (kidx == 8'(KEY_BYTES - 1)) ? '0 : kidx + 8'd1;
        if (i == 8'hFF) begin
          j_n     = '0;
          state_n = PLEN_R;
        end else begin
          state_n = KSA_RI;
        end
      end
      PLEN_R: begin
        pt_addr = '0;
        state_n = PLEN_W;
      end
      PLEN_W: begin
        len_n     = pt_rddata;
        ct_addr   = '0;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
        k_n       = 8'd1;
        state_n   = (pt_rddata == 8'd0) ? DONE : PRGA_I;
      end
      PRGA_I: begin
        i_n     = i + 8'd1;
        s_addr  = i + 8'd1;
        state_n = PRGA_J;
      end
      PRGA_J: begin
        si_n    = s_rddata;
        jsum    = j + s_rddata;
        j_n     = jsum;
        s_addr  = jsum;
        state_n = PRGA_WI;
      end
      PRGA_WI: begin
        sj_n     = s_rddata;
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_n  = PRGA_WJ;
      end
      PRGA_WJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        state_n  = PRGA_PAD;
      end
      PRGA_PAD: begin
        // swap leaves the sum unchanged, so the pre-swap values address the pad
        s_addr  = si + sj;
        pt_addr = k;
        state_n = PRGA_OUT;
      end
      PRGA_OUT: begin
        ct_addr   = k;
        ct_wrdata = s_rddata ^ pt_rddata;
        ct_wren   = 1'b1;
        k_n       = k + 8'd1;
        state_n   = (k == len) ? DONE : PRGA_I;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
